// File: rtl/hilo_mul_unit.sv
// Iterative unsigned MULTU/MADDU unit with architectural HI/LO pair.
// Optional HILO_EARLY_TERM_EN: finish once the shifted multiplier is zero.
module hilo_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_maddu,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_maddu;
  logic               r_done;

  logic [2*WIDTH-1:0] w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_res;
  logic               w_last;

  // Multiplicand is kept pre-shifted so each step is a plain add.
  assign w_add  = r_b[0] ? r_mcand : '0;
  assign w_prod = r_prod + w_add;
  assign w_acc  = r_maddu ? {r_hi, r_lo} : '0;
  assign w_res  = w_acc + w_prod;

`ifdef HILO_EARLY_TERM_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                  (r_b[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_maddu <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_mcand <= {{WIDTH{1'b0}}, src_a};
            r_b     <= src_b;
            r_maddu <= op_maddu;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (w_last) begin
            {r_hi, r_lo} <= w_res;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_prod  <= w_prod;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign stall = busy & (hilo_rd | start);

endmodule
